// File: rtl/imm_enc_pkg.sv
// -----------------------------------------------------------------------------
// imm_enc_pkg
// Shared definitions for the RISC-V immediate encoder (and the matching
// decoder): immediate format codes and the lowest bit index of the range
// that must be pure sign extension for each format.
// -----------------------------------------------------------------------------
package imm_enc_pkg;

    // Same encoding as the decoder's ImmSrc
    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    // imm[31:LSB] must all be equal for the value to be representable
    localparam int IMM_IS_SEXT_LSB = 11;
    localparam int IMM_B_SEXT_LSB  = 12;
    localparam int IMM_J_SEXT_LSB  = 20;

    // Instruction bit positions occupied by the immediate of each format
    localparam logic [31:0] IMM_I_MASK  = 32'hFFF0_0000;
    localparam logic [31:0] IMM_SB_MASK = 32'hFE00_0F80;
    localparam logic [31:0] IMM_J_MASK  = 32'hFFFF_F000;

endpackage

// File: rtl/imm_pack.sv
// -----------------------------------------------------------------------------
// imm_pack
// Combinational scatter of a 32-bit signed immediate into RISC-V I/S/B/J
// instruction bit positions, merged with a base instruction word, plus the
// range check. Out-of-range immediates leave the immediate field zero.
//
// Ports:
//   i_imm        signed immediate (byte offset for B/J)
//   i_src        immediate format (imm_src_e encoding)
//   i_base       base instruction; immediate bit positions are ignored
//   o_instr      merged instruction
//   o_range_err  immediate not representable in the selected format
// -----------------------------------------------------------------------------
module imm_pack
    import imm_enc_pkg::*;
(
    input  logic signed [31:0] i_imm,
    input  logic        [1:0]  i_src,
    input  logic        [31:0] i_base,
    output logic        [31:0] o_instr,
    output logic               o_range_err
);

    // True when v[31:lsb] are all copies of the sign bit
    function automatic logic upper_equal(input logic [31:0] v, input int lsb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= lsb && v[i] != v[31]) ok = 1'b0;
        end
        return ok;
    endfunction

    logic [31:0] w_field;
    logic [31:0] w_mask;
    logic        w_ok;

    always_comb begin
        w_field = '0;
        w_mask  = IMM_I_MASK;
        w_ok    = 1'b1;
        unique case (imm_src_e'(i_src))
            IMM_I: begin
                w_field = {i_imm[11:0], 20'b0};
                w_mask  = IMM_I_MASK;
                w_ok    = upper_equal(i_imm, IMM_IS_SEXT_LSB);
            end
            IMM_S: begin
                w_field = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
                w_mask  = IMM_SB_MASK;
                w_ok    = upper_equal(i_imm, IMM_IS_SEXT_LSB);
            end
            IMM_B: begin
                w_field = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
                w_mask  = IMM_SB_MASK;
                w_ok    = upper_equal(i_imm, IMM_B_SEXT_LSB) && !i_imm[0];
            end
            IMM_J: begin
                w_field = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
                w_mask  = IMM_J_MASK;
                w_ok    = upper_equal(i_imm, IMM_J_SEXT_LSB) && !i_imm[0];
            end
            default: ;
        endcase
    end

    // Immediate positions are zeroed on a range failure; all other bits pass through
    assign o_instr     = (i_base & ~w_mask) | (w_ok ? w_field : 32'b0);
    assign o_range_err = !w_ok;

endmodule

// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
// Two-stage elastic pipeline that builds I/S/B/J instructions from a signed
// immediate and a base instruction word. S1 registers the request and packs it
// (imm_pack); S2 holds the packed result that drives the outputs.
//
// Optional build macro: IMM_ENC_SELFCHECK_EN adds the selfchk_err output, which
// re-extends the delivered instruction and flags a mismatch against the stored
// immediate on the output handshake.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   imm_in, imm_src     signed immediate and format (imm_src_e)
//   base_instr          opcode/register/funct fields
//   out_valid/out_ready downstream handshake
//   instr_out           encoded instruction
//   range_err           immediate not representable (qualifies instr_out)
//   enc_cnt, err_cnt    delivered results / delivered with range_err (wrap)
//   selfchk_err         (IMM_ENC_SELFCHECK_EN only) re-extension mismatch pulse
// -----------------------------------------------------------------------------
module imm_encoder
    import imm_enc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      imm_in,
    input  logic [1:0]       imm_src,
    input  logic [31:0]      base_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr_out,
    output logic             range_err,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
`ifdef IMM_ENC_SELFCHECK_EN
    ,
    output logic             selfchk_err
`endif
);

    logic               r_vld_p1;
    logic signed [31:0] r_imm_p1;
    logic        [1:0]  r_src_p1;
    logic        [31:0] r_base_p1;

    logic               r_vld_p2;
    logic        [31:0] r_instr_p2;
    logic               r_rerr_p2;

    logic        [31:0] w_instr;
    logic               w_rerr;
    logic               w_adv_p2;
    logic               w_acc;
    logic               w_hs_out;

    assign w_adv_p2  = !r_vld_p2 || out_ready;
    // Equivalent to "S1 empty or S1 advances"; gated low while in reset
    assign in_ready  = rst && (!r_vld_p1 || !r_vld_p2 || out_ready);
    assign w_acc     = in_valid && in_ready;
    assign w_hs_out  = r_vld_p2 && out_ready;

    assign out_valid = r_vld_p2;
    assign instr_out = r_instr_p2;
    assign range_err = r_rerr_p2;

    // ---- stage 1: registered request ----
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_imm_p1  <= imm_in;
            r_src_p1  <= imm_src;
            r_base_p1 <= base_instr;
        end
    end

    imm_pack u_pack (
        .i_imm       (r_imm_p1),
        .i_src       (r_src_p1),
        .i_base      (r_base_p1),
        .o_instr     (w_instr),
        .o_range_err (w_rerr)
    );

    // ---- stage 2: packed result, valids and counters ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_p1   <= 1'b0;
            r_vld_p2   <= 1'b0;
            r_instr_p2 <= '0;
            r_rerr_p2  <= 1'b0;
            enc_cnt    <= '0;
            err_cnt    <= '0;
        end else begin
            if (in_ready) r_vld_p1 <= w_acc;
            if (w_adv_p2) begin
                r_vld_p2 <= r_vld_p1;
                // Only real items overwrite the output word
                if (r_vld_p1) begin
                    r_instr_p2 <= w_instr;
                    r_rerr_p2  <= w_rerr;
                end
            end
            if (w_hs_out) begin
                enc_cnt <= enc_cnt + 1'b1;
                if (r_rerr_p2) err_cnt <= err_cnt + 1'b1;
            end
        end
    end

`ifdef IMM_ENC_SELFCHECK_EN
    logic signed [31:0] r_imm_p2;
    logic        [1:0]  r_src_p2;

    // Decoder-side sign extension of the packed instruction
    function automatic logic [31:0] reextend(input logic [31:0] i, input logic [1:0] src);
        logic [31:0] v;
        unique case (imm_src_e'(src))
            IMM_I:   v = {{20{i[31]}}, i[31:20]};
            IMM_S:   v = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (w_adv_p2 && r_vld_p1) begin
            r_imm_p2 <= r_imm_p1;
            r_src_p2 <= r_src_p1;
        end
    end

    assign selfchk_err = w_hs_out && !r_rerr_p2 &&
                         (reextend(r_instr_p2, r_src_p2) != r_imm_p2);
`endif

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      imm_in;
    logic [1:0]       imm_src;
    logic [31:0]      base_instr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      instr_out;
    logic             range_err;
    logic [CNT_W-1:0] enc_cnt;
    logic [CNT_W-1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    imm_encoder #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imm_in     (imm_in),
        .imm_src    (imm_src),
        .base_instr (base_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr_out  (instr_out),
        .range_err  (range_err),
        .enc_cnt    (enc_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one item with out_ready=1, check latency, result, then let it drain
    task automatic run_item(input string tag, input logic [31:0] imm, input logic [1:0] src,
                            input logic [31:0] base, input logic [31:0] exp_instr,
                            input logic exp_err);
        int cyc;
        imm_in     = imm;
        imm_src    = src;
        base_instr = base;
        in_valid   = 1'b1;
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            step();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 32'd2);
        check({tag, "_instr"}, instr_out, exp_instr);
        check({tag, "_range_err"}, {31'b0, range_err}, {31'b0, exp_err});
        step();
        check({tag, "_drained"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        imm_in     = '0;
        imm_src    = 2'b00;
        base_instr = '0;
        #1;
        check("rst_in_ready",  {31'b0, in_ready},  32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_instr",     instr_out,          32'd0);
        check("rst_range_err", {31'b0, range_err}, 32'd0);
        check("rst_enc_cnt",   {16'b0, enc_cnt},   32'd0);
        check("rst_err_cnt",   {16'b0, err_cnt},   32'd0);
        step();
        step();
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Formats
        run_item("I_neg1", 32'hFFFF_FFFF, 2'b00, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
        run_item("S_7ff",  32'h0000_07FF, 2'b01, 32'h0000_2023, 32'h7E00_2FA3, 1'b0);
        run_item("B_m4",   32'hFFFF_FFFC, 2'b10, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
        run_item("J_8",    32'h0000_0008, 2'b11, 32'h0000_006F, 32'h0080_006F, 1'b0);
        check("err_cnt_before", {16'b0, err_cnt}, 32'd0);

        // Range errors
        run_item("I_800",  32'h0000_0800, 2'b00, 32'h0000_0013, 32'h0000_0013, 1'b1);
        check("err_cnt_1", {16'b0, err_cnt}, 32'd1);
        check("enc_cnt_5", {16'b0, enc_cnt}, 32'd5);
        run_item("B_odd",  32'h0000_0003, 2'b10, 32'h0000_0063, 32'h0000_0063, 1'b1);
        check("err_cnt_2", {16'b0, err_cnt}, 32'd2);
        run_item("J_min",  32'hFFF0_0000, 2'b11, 32'h0000_00EF, 32'h8000_00EF, 1'b0);

        // Backpressure: fresh counters first
        rst = 1'b0;
        #1;
        check("rst2_enc_cnt", {16'b0, enc_cnt}, 32'd0);
        step();
        rst = 1'b1;
        out_ready = 1'b0;
        #1;
        imm_src    = 2'b00;
        base_instr = 32'h0000_0013;
        imm_in     = 32'd1;
        in_valid   = 1'b1;
        check("bp_acc_a", {31'b0, in_ready}, 32'd1);
        step();
        imm_in = 32'd2;
        check("bp_acc_b", {31'b0, in_ready}, 32'd1);
        step();
        imm_in = 32'd3;
        check("bp_full", {31'b0, in_ready}, 32'd0);
        step();
        check("bp_full_2",  {31'b0, in_ready},  32'd0);
        check("bp_valid",   {31'b0, out_valid}, 32'd1);
        check("bp_hold_a",  instr_out,          32'h0010_0013);
        step();
        check("bp_hold_a2", instr_out,          32'h0010_0013);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_out_b", instr_out,          32'h0020_0013);
        check("bp_vld_b", {31'b0, out_valid}, 32'd1);
        step();
        check("bp_out_c", instr_out,          32'h0030_0013);
        check("bp_vld_c", {31'b0, out_valid}, 32'd1);
        step();
        check("bp_empty",   {31'b0, out_valid}, 32'd0);
        check("bp_enc_cnt", {16'b0, enc_cnt},   32'd3);

        // Reset while both stages hold items
        out_ready = 1'b0;
        imm_in    = 32'd5;
        in_valid  = 1'b1;
        step();
        imm_in = 32'd6;
        step();
        in_valid = 1'b0;
        check("mid_full", {31'b0, out_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid",   {31'b0, out_valid}, 32'd0);
        check("mid_rst_enc_cnt", {16'b0, enc_cnt},   32'd0);
        check("mid_rst_ready",   {31'b0, in_ready},  32'd0);
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mid_post_valid", {31'b0, out_valid}, 32'd0);
        run_item("after_rst", 32'hFFFF_F800, 2'b01, 32'h0000_2023, 32'h8000_2023, 1'b0);
        check("after_rst_enc_cnt", {16'b0, enc_cnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
